minmax_tracker: RTL and testbench



---
 rtl/minmax_pkg.sv | 17 +
 rtl/signed_lt.sv | 12 +
 rtl/minmax_tracker.sv | 136 +++++++++++++
 tb/tb_minmax_tracker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max frame tracker.
package minmax_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned W_DEF         = 6;
    localparam int unsigned FRAME_LEN_DEF = 8;

    // Width needed to hold a sample count from 0 to n inclusive.
    function automatic int unsigned cw_of(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/signed_lt.sv
// W-bit combinational signed less-than: lt = (a < b) in two's complement.
module signed_lt #(
    parameter int unsigned W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);

    assign lt = ($signed(a) < $signed(b));

endmodule

// File: rtl/minmax_tracker.sv
// Running signed min/max over frames of samples, result presented over valid/ready.
// Optional MINMAX_INDEX_EN adds min_idx/max_idx (first-occurrence positions).
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned W         = W_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned CW        = cw_of(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  min_out,
    output logic [W-1:0]  max_out,
`ifdef MINMAX_INDEX_EN
    output logic [CW-1:0] min_idx,
    output logic [CW-1:0] max_idx,
`endif
    output logic [CW-1:0] frame_cnt
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [W-1:0]  run_min;
    logic [W-1:0]  run_max;
    logic [W-1:0]  min_nxt;
    logic [W-1:0]  max_nxt;
    logic          lt_min;
    logic          gt_max;
    logic          accept;
    logic          close;
    logic          out_hs;
    logic          first;
`ifdef MINMAX_INDEX_EN
    logic [CW-1:0] run_min_idx;
    logic [CW-1:0] run_max_idx;
    logic [CW-1:0] min_idx_nxt;
    logic [CW-1:0] max_idx_nxt;
`endif

    signed_lt #(.W(W)) u_lt_min (.a(in_data), .b(run_min), .lt(lt_min));
    signed_lt #(.W(W)) u_lt_max (.a(run_max), .b(in_data), .lt(gt_max));

    assign in_ready = (state == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;
    assign first    = (count == '0);
    assign close    = accept && ((count == CW'(FRAME_LEN - 1)) || in_last);
    assign out_hs   = (state == HOLD) && out_valid && out_ready;

    // Candidate min/max including the current sample; ties keep the stored value.
    always_comb begin
        min_nxt = run_min;
        max_nxt = run_max;
        if (first || lt_min) min_nxt = in_data;
        if (first || gt_max) max_nxt = in_data;
    end

`ifdef MINMAX_INDEX_EN
    always_comb begin
        min_idx_nxt = run_min_idx;
        max_idx_nxt = run_max_idx;
        if (first || lt_min) min_idx_nxt = count;
        if (first || gt_max) max_idx_nxt = count;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (close)  state_nxt = HOLD;
            HOLD:    if (out_hs) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Running accumulators and the presented frame result.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            run_min   <= '0;
            run_max   <= '0;
            out_valid <= 1'b0;
            min_out   <= '0;
            max_out   <= '0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                count   <= count + CW'(1);
                run_min <= min_nxt;
                run_max <= max_nxt;
            end
            if (close) begin
                out_valid <= 1'b1;
                min_out   <= min_nxt;
                max_out   <= max_nxt;
                frame_cnt <= count + CW'(1);
            end
            if (out_hs) begin
                out_valid <= 1'b0;
                count     <= '0;
            end
        end
    end

`ifdef MINMAX_INDEX_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            run_min_idx <= '0;
            run_max_idx <= '0;
            min_idx     <= '0;
            max_idx     <= '0;
        end else begin
            if (accept) begin
                run_min_idx <= min_idx_nxt;
                run_max_idx <= max_idx_nxt;
            end
            if (close) begin
                min_idx <= min_idx_nxt;
                max_idx <= max_idx_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: three instances with FRAME_LEN = 4, 8, 1.
module tb_minmax_tracker;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [2:0] in_last;
    logic [2:0] out_valid;
    logic [2:0] out_ready;
    logic [5:0] in_data [3];
    logic [5:0] min_o   [3];
    logic [5:0] max_o   [3];
    logic [3:0] fc      [3];
    logic [2:0] fc4;
    logic [3:0] fc8;
    logic [0:0] fc1;
`ifdef MINMAX_INDEX_EN
    logic [2:0] mi4, xi4;
    logic [3:0] mi8, xi8;
    logic [0:0] mi1, xi1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign fc[0] = 4'(fc4);
    assign fc[1] = fc8;
    assign fc[2] = 4'(fc1);

    minmax_tracker #(.W(6), .FRAME_LEN(4)) u_fl4 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .min_out(min_o[0]), .max_out(max_o[0]),
`ifdef MINMAX_INDEX_EN
        .min_idx(mi4), .max_idx(xi4),
`endif
        .frame_cnt(fc4)
    );

    minmax_tracker #(.W(6), .FRAME_LEN(8)) u_fl8 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .min_out(min_o[1]), .max_out(max_o[1]),
`ifdef MINMAX_INDEX_EN
        .min_idx(mi8), .max_idx(xi8),
`endif
        .frame_cnt(fc8)
    );

    minmax_tracker #(.W(6), .FRAME_LEN(1)) u_fl1 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .min_out(min_o[2]), .max_out(max_o[2]),
`ifdef MINMAX_INDEX_EN
        .min_idx(mi1), .max_idx(xi1),
`endif
        .frame_cnt(fc1)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample on instance d; returns #1 after the accepting edge.
    task automatic send(input int d, input logic signed [5:0] v, input logic l);
        int k = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_data[d]  = v;
        in_last[d]  = l;
        while (!in_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("send_timeout", 32'(k), 0);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int d, input logic signed [5:0] mn,
                           input logic signed [5:0] mx, input int cnt);
        chk({tag, "_valid"}, 32'(out_valid[d]), 1);
        chk({tag, "_min"}, 32'($signed(min_o[d])), 32'(mn));
        chk({tag, "_max"}, 32'($signed(max_o[d])), 32'(mx));
        chk({tag, "_cnt"}, 32'(fc[d]), 32'(cnt));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 3'b111;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 3'b111;
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", 32'(out_valid[i]), 0);
            chk("rst_ready", 32'(in_ready[i]), 0);
            chk("rst_min", 32'(min_o[i]), 0);
            chk("rst_max", 32'(max_o[i]), 0);
            chk("rst_cnt", 32'(fc[i]), 0);
        end
        @(negedge clk);
        rst = '0;

        // FRAME_LEN=4: extremes of the signed range
        send(0, 6'sd3, 1'b0);
        send(0, -6'sd5, 1'b0);
        send(0, 6'sd31, 1'b0);
        chk("fl4_partial_valid", 32'(out_valid[0]), 0);
        send(0, -6'sd32, 1'b0);
        chk_res("fl4", 0, -6'sd32, 6'sd31, 4);
`ifdef MINMAX_INDEX_EN
        chk("fl4_min_idx", 32'(mi4), 3);
        chk("fl4_max_idx", 32'(xi4), 2);
`endif
        tick(1);
        chk("fl4_hs_valid", 32'(out_valid[0]), 0);
        chk("fl4_hs_ready", 32'(in_ready[0]), 1);

        // FRAME_LEN=8 with early in_last and ties
        send(1, 6'sd7, 1'b0);
        send(1, 6'sd7, 1'b0);
        send(1, -6'sd1, 1'b0);
        send(1, 6'sd7, 1'b0);
        send(1, -6'sd1, 1'b1);
        chk_res("last5", 1, -6'sd1, 6'sd7, 5);
`ifdef MINMAX_INDEX_EN
        chk("last5_min_idx", 32'(mi8), 2);
        chk("last5_max_idx", 32'(xi8), 0);
`endif

        // Backpressure: result held, new sample stalled then accepted
        @(negedge clk);
        out_ready[0] = 1'b0;
        send(0, 6'sd1, 1'b0);
        send(0, -6'sd2, 1'b0);
        send(0, 6'sd5, 1'b0);
        send(0, 6'sd0, 1'b0);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 6'sd9;
        for (int c = 0; c < 5; c++) begin
            chk("bp_ready", 32'(in_ready[0]), 0);
            chk_res("bp", 0, -6'sd2, 6'sd5, 4);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        tick(1);
        chk("bp_hs_valid", 32'(out_valid[0]), 0);
        chk("bp_hs_ready", 32'(in_ready[0]), 1);
        tick(1);
        in_valid[0] = 1'b0;
        send(0, -6'sd3, 1'b0);
        send(0, 6'sd4, 1'b0);
        send(0, 6'sd2, 1'b0);
        chk_res("bp_kept", 0, -6'sd3, 6'sd9, 4);

        // Reset mid-frame discards the partial frame
        send(0, 6'sd1, 1'b0);
        send(0, 6'sd2, 1'b0);
        @(negedge clk);
        rst[0] = 1'b1;
        tick(1);
        chk("mrst_valid", 32'(out_valid[0]), 0);
        chk("mrst_min", 32'(min_o[0]), 0);
        chk("mrst_max", 32'(max_o[0]), 0);
        chk("mrst_cnt", 32'(fc[0]), 0);
        chk("mrst_ready", 32'(in_ready[0]), 0);
        @(negedge clk);
        rst[0] = 1'b0;
        send(0, 6'sd1, 1'b0);
        send(0, 6'sd2, 1'b0);
        send(0, 6'sd3, 1'b0);
        send(0, 6'sd4, 1'b0);
        chk_res("fresh", 0, 6'sd1, 6'sd4, 4);

        // FRAME_LEN=1: each sample is its own frame
        send(2, -6'sd32, 1'b0);
        chk_res("fl1_a", 2, -6'sd32, -6'sd32, 1);
        send(2, 6'sd31, 1'b0);
        chk_res("fl1_b", 2, 6'sd31, 6'sd31, 1);

        // in_last on the natural final sample closes once
        tick(2);
        send(0, 6'sd5, 1'b0);
        send(0, 6'sd6, 1'b0);
        send(0, 6'sd7, 1'b0);
        send(0, 6'sd8, 1'b1);
        chk_res("dbl", 0, 6'sd5, 6'sd8, 4);
        tick(1);
        chk("dbl_drop", 32'(out_valid[0]), 0);
        tick(3);
        chk("dbl_none", 32'(out_valid[0]), 0);
        send(0, -6'sd4, 1'b1);
        chk_res("next", 0, -6'sd4, -6'sd4, 1);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
